// File: rtl/lift_pkg.sv
// Shared constants for the lift call scheduler: default sizing, sweep
// direction encodings and the FSM state type.
package lift_pkg;

    localparam int NUM_FLOORS_DEF = 6;
    localparam int FLOOR_W_DEF    = 3;

    localparam logic [1:0] SWEEP_IDLE = 2'b00;
    localparam logic [1:0] SWEEP_UP   = 2'b01;
    localparam logic [1:0] SWEEP_DOWN = 2'b10;

    // State codes equal the sweep encodings so sweep_dir is the state register itself.
    typedef enum logic [1:0] {
        ST_IDLE = SWEEP_IDLE,
        ST_UP   = SWEEP_UP,
        ST_DOWN = SWEEP_DOWN
    } state_t;

endpackage

// File: rtl/lift_call_latch.sv
// One bank of call buttons: rising-edge capture into a pending register,
// with clear taking priority over a same-cycle set and a per-floor ignore mask.
module lift_call_latch
    import lift_pkg::*;
#(
    parameter int                    NUM_FLOORS  = NUM_FLOORS_DEF,
    parameter logic [NUM_FLOORS-1:0] IGNORE_MASK = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] i_btn,
    input  logic [NUM_FLOORS-1:0] i_clr,
    output logic [NUM_FLOORS-1:0] o_pending
);

    logic [NUM_FLOORS-1:0] r_prev;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] w_rise;

    assign w_rise = i_btn & ~r_prev & ~IGNORE_MASK;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev    <= i_btn;
            r_pending <= (r_pending | w_rise) & ~i_clr;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/lift_call_scheduler.sv
// SCAN scheduler: latches hall and car calls, picks the next target floor in
// the current sweep direction and clears calls served at a door-open stop.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] move_up_call,
    input  logic [NUM_FLOORS-1:0] move_down_call,
    input  logic [NUM_FLOORS-1:0] req_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  at_floor,
    input  logic                  sensor_failure,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic [1:0]            sweep_dir,
    output logic [NUM_FLOORS-1:0] pending_up,
    output logic [NUM_FLOORS-1:0] pending_down,
    output logic [NUM_FLOORS-1:0] pending_car
);

    localparam logic [NUM_FLOORS-1:0] UP_IGNORE   = {1'b1, {(NUM_FLOORS-1){1'b0}}};
    localparam logic [NUM_FLOORS-1:0] DOWN_IGNORE = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_next;
    logic [FLOOR_W-1:0]    r_target;
    logic [FLOOR_W-1:0]    w_target_next;
    logic                  r_valid;
    logic                  w_valid_next;

    logic [NUM_FLOORS-1:0] w_clr_up, w_clr_down, w_clr_car;
    logic [NUM_FLOORS-1:0] w_all;
    logic [NUM_FLOORS-1:0] w_above_mask, w_below_mask, w_here_oh;
    logic                  w_above, w_below, w_here, w_cur_ok;
    logic [NUM_FLOORS-1:0] w_up_pri, w_up_alt, w_dn_pri, w_dn_alt;
    logic [FLOOR_W-1:0]    w_up_target, w_dn_target;

    function automatic logic [FLOOR_W-1:0] lowest_idx(input logic [NUM_FLOORS-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (v[i]) lowest_idx = FLOOR_W'(i);
    endfunction

    function automatic logic [FLOOR_W-1:0] highest_idx(input logic [NUM_FLOORS-1:0] v);
        highest_idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (v[i]) highest_idx = FLOOR_W'(i);
    endfunction

    lift_call_latch #(.NUM_FLOORS(NUM_FLOORS), .IGNORE_MASK(UP_IGNORE)) u_up_latch (
        .clk(clk), .rst(rst), .i_btn(move_up_call), .i_clr(w_clr_up), .o_pending(pending_up)
    );

    lift_call_latch #(.NUM_FLOORS(NUM_FLOORS), .IGNORE_MASK(DOWN_IGNORE)) u_down_latch (
        .clk(clk), .rst(rst), .i_btn(move_down_call), .i_clr(w_clr_down), .o_pending(pending_down)
    );

    lift_call_latch #(.NUM_FLOORS(NUM_FLOORS), .IGNORE_MASK('0)) u_car_latch (
        .clk(clk), .rst(rst), .i_btn(req_floor), .i_clr(w_clr_car), .o_pending(pending_car)
    );

    // An out-of-range floor gives an empty here/above set; the FSM ignores demand then.
    always_comb begin
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_above_mask[i] = (i > int'(current_floor));
            w_below_mask[i] = (i < int'(current_floor));
            w_here_oh[i]    = (i == int'(current_floor));
        end
    end

    assign w_cur_ok = (int'(current_floor) < NUM_FLOORS);
    assign w_all    = pending_up | pending_down | pending_car;
    assign w_above  = |(w_all & w_above_mask);
    assign w_below  = |(w_all & w_below_mask);
    assign w_here   = |(w_all & w_here_oh);

    assign w_up_pri    = (pending_car | pending_up) & w_above_mask;
    assign w_up_alt    = pending_down & w_above_mask;
    assign w_dn_pri    = (pending_car | pending_down) & w_below_mask;
    assign w_dn_alt    = pending_up & w_below_mask;
    assign w_up_target = (|w_up_pri) ? lowest_idx(w_up_pri) : highest_idx(w_up_alt);
    assign w_dn_target = (|w_dn_pri) ? highest_idx(w_dn_pri) : lowest_idx(w_dn_alt);

    always_comb begin
        w_clr_car  = '0;
        w_clr_up   = '0;
        w_clr_down = '0;
        if (at_floor) begin
            w_clr_car = w_here_oh;
            unique case (r_state)
                ST_UP: begin
                    w_clr_up   = w_here_oh;
                    w_clr_down = w_above ? '0 : w_here_oh;
                end
                ST_DOWN: begin
                    w_clr_down = w_here_oh;
                    w_clr_up   = w_below ? '0 : w_here_oh;
                end
                default: begin
                    w_clr_up   = w_here_oh;
                    w_clr_down = w_here_oh;
                end
            endcase
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        w_state_next  = r_state;
        w_target_next = r_target;
        w_valid_next  = r_valid;
        if (sensor_failure) begin
            w_valid_next = 1'b0;
        end else if (w_cur_ok) begin
            unique case (r_state)
                ST_DOWN: w_state_next = w_below ? ST_DOWN : (w_above ? ST_UP : ST_IDLE);
                default: w_state_next = w_above ? ST_UP : (w_below ? ST_DOWN : ST_IDLE);
            endcase
            w_valid_next = 1'b1;
            unique case (w_state_next)
                ST_UP:   w_target_next = w_up_target;
                ST_DOWN: w_target_next = w_dn_target;
                default: begin
                    if (w_here) w_target_next = current_floor;
                    else        w_valid_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_target <= w_target_next;
            r_valid  <= w_valid_next;
        end
    end

    assign target_floor = r_target;
    assign target_valid = r_valid;
    assign sweep_dir    = r_state;

endmodule

// File: doc/lift_call_scheduler.md
# lift_call_scheduler

Upstream request stage of the lift controller. Captures hall up/down and in-car button presses, holds them as pending calls, and runs a SCAN (sweep) policy that presents the controller with one registered target floor at a time. Served calls are cleared when the controller reports that the cabin is stopped with its door open.

## Interface

Parameters:
- NUM_FLOORS, 6, number of landings, floors 0..NUM_FLOORS-1
- FLOOR_W, 3, floor index width, must satisfy 2**FLOOR_W >= NUM_FLOORS

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- move_up_call  in  NUM_FLOORS  hall up buttons, level; bit NUM_FLOORS-1 ignored
- move_down_call  in  NUM_FLOORS  hall down buttons, level; bit 0 ignored
- req_floor  in  NUM_FLOORS  in-car floor buttons, level
- current_floor  in  FLOOR_W  cabin position from controller
- at_floor  in  1  one-cycle pulse: cabin stopped at current_floor, door open
- sensor_failure  in  1  while high, no target is issued
- target_floor  out  FLOOR_W  next floor to serve, registered
- target_valid  out  1  target_floor is meaningful
- sweep_dir  out  2  00 idle, 01 up, 10 down; 11 never driven
- pending_up  out  NUM_FLOORS  latched hall-up calls (lamp drive)
- pending_down  out  NUM_FLOORS  latched hall-down calls
- pending_car  out  NUM_FLOORS  latched car calls

## Operation

- Capture: each button bit has a previous-value register. A rising edge (in & ~prev) sets the matching pending bit. A level held high does not re-set a cleared bit. prev registers reset to 0, so a button held high across reset release registers once.
- Ignored bits: move_up_call[top] and move_down_call[0] never set a pending bit.
- Demand sets: above = any pending bit at floor > current_floor. below = any at floor < current_floor. here = any at current_floor.
- FSM states: IDLE, UP, DOWN. sweep_dir mirrors the state.
  - IDLE: above -> UP; else below -> DOWN. If only here: stay IDLE, target = current_floor, valid = 1.
  - UP: target = lowest floor > current with car or up call. If none, target = highest floor > current with a down call. If no demand above: below -> DOWN, else IDLE.
  - DOWN: symmetric (highest floor < current with car or down call; else lowest < current with an up call). If no demand below: above -> UP, else IDLE.
- Service on at_floor at floor f:
  - clear pending_car[f];
  - clear the hall call at f matching the sweep direction; both hall calls in IDLE;
  - if there is no further demand in the sweep direction, also clear the opposite hall call at f.
- A press at f in the same cycle as at_floor at f is treated as served: clear wins.
- sensor_failure high:
  - target_valid = 0 and FSM holds its state;
  - capture and service clearing still operate;
  - normal scheduling resumes on the first cycle after it deasserts.
- current_floor >= NUM_FLOORS: treated as no demand here; FSM holds.

## Timing

- Reset values: all pending 0, prev 0, state IDLE, target_floor 0, target_valid 0, sweep_dir 00.
- Press sampled high at edge k -> pending bit visible after edge k (1 cycle).
- Target and state update at edge k+1 (press-to-target latency 2 cycles).
- at_floor at edge k -> pending cleared after edge k; the new target appears after edge k+1.
- All outputs are registered; there are no combinational paths from input to output.
- Asserting rst mid-sweep clears everything immediately; calls lost on reset are not recovered.

## Structure

- Package lift_pkg holds:
  - NUM_FLOORS and FLOOR_W defaults;
  - sweep encodings SWEEP_IDLE/UP/DOWN;
  - the FSM state constants.
- Sub-module lift_call_latch(NUM_FLOORS) contains the edge-detect register, pending register, set/clear priority (clear wins) and ignore mask. It is instantiated three times, once each for up, down and car calls.
- Top lift_call_scheduler contains:
  - the demand reduction;
  - the priority search (lowest/highest set bit relative to current_floor);
  - the FSM and the output registers.

## Test plan

- Reset, then idle with current_floor=0: after rst falls, all pending 0, target_valid 0, sweep_dir 00; no change for 10 cycles.
- Single hall call, cabin at floor 0: pulse move_up_call[2] -> pending_up[2]=1 after 1 cycle; target_floor=2, sweep_dir=01, valid=1 after 2 cycles. Then current_floor=2 plus at_floor -> pending_up[2]=0 and sweep_dir=00.
- Sweep ordering, cabin at floor 1 going up: pending req_floor[4], move_up_call[3], move_down_call[5], req_floor[0] -> targets served in order 3, 4, 5, then DOWN, then 0.
- Top/bottom masks: move_up_call[5] and move_down_call[0] pulsed -> no pending bits set, target_valid stays 0.
- sensor_failure with req_floor[3] pending: target_valid=0 while high, pending_car[3] stays 1; valid returns with target 3 on the first cycle after deassert.
- Clear wins: req_floor[2] rising in the same cycle as at_floor with current_floor=2 -> pending_car[2] stays 0. Asserting rst mid-UP sweep returns all outputs to their reset values.
